// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: requester tags and
// default bus widths matching the CPU data path.
package dmem_arb_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 8;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/dmem_arb_rd_tag_pipe.sv
// Valid+tag delay line that follows each granted read through the memory
// read latency so the return can be steered to the right requester.
module rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic tag,
    output logic out_valid,
    output logic out_tag
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] tg;

    // Clearing on reset discards any reads still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            tg  <= {DEPTH{REQ_CPU}};
        end else begin
            vld[0] <= push;
            tg[0]  <= tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tg[i]  <= tg[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tg[DEPTH-1];

endmodule

// File: rtl/dmem_arb.sv
// Arbiter sharing the single-port data memory between the CPU MEM stage
// and the host/debug port, with round-robin fairness and a bounded host lock.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic              cpu_stall_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    input  logic              host_lock_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wen_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam int LCW = $clog2(MAX_LOCK + 1);

    logic           last_win;
    logic [LCW-1:0] lock_cnt;
    logic           lock_ok;
    logic           host_win;
    logic           cpu_gnt;
    logic           host_gnt;
    logic           rd_push;
    logic           pipe_valid;
    logic           pipe_tag;

    // Lock only extends an ongoing host run; once the counter saturates the
    // normal round-robin hands the next contended cycle to the CPU.
    always_comb begin
        lock_ok  = host_lock_i && (last_win == REQ_HOST) && (lock_cnt < LCW'(MAX_LOCK));
        host_win = host_req_i;
        if (cpu_req_i && host_req_i) begin
            host_win = lock_ok || (last_win == REQ_CPU);
        end
    end

    assign cpu_gnt  = cpu_req_i && !host_win;
    assign host_gnt = host_req_i && host_win;

    assign cpu_gnt_o   = cpu_gnt;
    assign host_gnt_o  = host_gnt;
    assign cpu_stall_o = cpu_req_i && !cpu_gnt;

    assign mem_addr_o = host_gnt ? host_addr_i  : cpu_addr_i;
    assign mem_data_o = host_gnt ? host_wdata_i : cpu_wdata_i;
    assign mem_wen_o  = (host_gnt && host_we_i) || (cpu_gnt && cpu_we_i);

    assign rd_push = (cpu_gnt && !cpu_we_i) || (host_gnt && !host_we_i);

    // Reset to HOST so the CPU takes the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= REQ_HOST;
            lock_cnt <= '0;
        end else begin
            if (cpu_gnt) begin
                last_win <= REQ_CPU;
            end else if (host_gnt) begin
                last_win <= REQ_HOST;
            end

            if (!host_lock_i || cpu_gnt) begin
                lock_cnt <= '0;
            end else if (host_gnt && cpu_req_i && (last_win == REQ_HOST) &&
                         (lock_cnt < LCW'(MAX_LOCK))) begin
                lock_cnt <= lock_cnt + LCW'(1);
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_push),
        .tag       (host_gnt ? REQ_HOST : REQ_CPU),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag)
    );

    assign cpu_rvalid_o  = pipe_valid && (pipe_tag == REQ_CPU);
    assign host_rvalid_o = pipe_valid && (pipe_tag == REQ_HOST);
    assign rdata_o       = mem_data_i;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: two instances (read latency 1 and 3)
// share stimulus and are compared every cycle against a behavioural model.
module tb_dmem_arb;

    localparam int DW      = 64;
    localparam int AW      = 8;
    localparam int LOCKMAX = 4;
    localparam int NSLOT   = 1024;

    logic          clk;
    logic          rst_n;
    logic          cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;

    logic          cpu_gnt_a, cpu_rv_a, stall_a, host_gnt_a, host_rv_a, wen_a;
    logic [DW-1:0] rdata_a, mdata_a, rdq_a;
    logic [AW-1:0] maddr_a;
    logic          cpu_gnt_b, cpu_rv_b, stall_b, host_gnt_b, host_rv_b, wen_b;
    logic [DW-1:0] rdata_b, mdata_b;
    logic [AW-1:0] maddr_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] m_mem   [256];
    logic          m_last;
    int            m_lock;
    logic          rv1_v [NSLOT];
    logic          rv1_t [NSLOT];
    logic [DW-1:0] rv1_d [NSLOT];
    logic          rv3_v [NSLOT];
    logic          rv3_t [NSLOT];

    logic          s_cpu_gnt, s_host_gnt, s_stall, s_wen, s_cpu_rv, s_host_rv;
    logic [DW-1:0] s_rdata;

    dmem_arb #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .MAX_LOCK(LOCKMAX)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt_a), .cpu_rvalid_o(cpu_rv_a), .cpu_stall_o(stall_a),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_lock_i(host_lock),
        .host_gnt_o(host_gnt_a), .host_rvalid_o(host_rv_a), .rdata_o(rdata_a),
        .mem_addr_o(maddr_a), .mem_data_o(mdata_a), .mem_wen_o(wen_a), .mem_data_i(rdq_a)
    );

    dmem_arb #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .MAX_LOCK(LOCKMAX)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt_b), .cpu_rvalid_o(cpu_rv_b), .cpu_stall_o(stall_b),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_lock_i(host_lock),
        .host_gnt_o(host_gnt_b), .host_rvalid_o(host_rv_b), .rdata_o(rdata_b),
        .mem_addr_o(maddr_b), .mem_data_o(mdata_b), .mem_wen_o(wen_b), .mem_data_i('0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with one cycle of read latency, attached to dut_a.
    always @(posedge clk) begin
        if (wen_a) env_mem[maddr_a] <= mdata_a;
        rdq_a <= env_mem[maddr_a];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Model: a lone requester wins; contention goes to whoever did not win
    // last, unless the host holds an unexpired lock on its own run.
    function automatic logic m_host_wins();
        if (!(cpu_req && host_req)) return host_req;
        if (host_lock && m_last && (m_lock < LOCKMAX)) return 1'b1;
        return !m_last;
    endfunction

    function automatic logic m_cg();
        return cpu_req && !m_host_wins();
    endfunction

    function automatic logic m_hg();
        return host_req && m_host_wins();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last <= 1'b1;
            m_lock <= 0;
            for (int i = 0; i < NSLOT; i++) begin
                rv1_v[i] <= 1'b0;
                rv3_v[i] <= 1'b0;
            end
        end else begin
            if (m_cg()) m_last <= 1'b0;
            else if (m_hg()) m_last <= 1'b1;
            if (!host_lock || m_cg()) m_lock <= 0;
            else if (m_hg() && cpu_req && m_last && (m_lock < LOCKMAX)) m_lock <= m_lock + 1;
            if (m_cg()) begin
                if (cpu_we) m_mem[cpu_addr] <= cpu_wdata;
                else begin
                    rv1_v[(cyc+1)%NSLOT] <= 1'b1; rv1_t[(cyc+1)%NSLOT] <= 1'b0;
                    rv1_d[(cyc+1)%NSLOT] <= m_mem[cpu_addr];
                    rv3_v[(cyc+3)%NSLOT] <= 1'b1; rv3_t[(cyc+3)%NSLOT] <= 1'b0;
                end
            end
            if (m_hg()) begin
                if (host_we) m_mem[host_addr] <= host_wdata;
                else begin
                    rv1_v[(cyc+1)%NSLOT] <= 1'b1; rv1_t[(cyc+1)%NSLOT] <= 1'b1;
                    rv1_d[(cyc+1)%NSLOT] <= m_mem[host_addr];
                    rv3_v[(cyc+3)%NSLOT] <= 1'b1; rv3_t[(cyc+3)%NSLOT] <= 1'b1;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("cpu_gnt_a",  DW'(cpu_gnt_a),  DW'(m_cg()));
            check_output("host_gnt_a", DW'(host_gnt_a), DW'(m_hg()));
            check_output("cpu_gnt_b",  DW'(cpu_gnt_b),  DW'(m_cg()));
            check_output("host_gnt_b", DW'(host_gnt_b), DW'(m_hg()));
            check_output("stall_a", DW'(stall_a), DW'(cpu_req && !m_cg()));
            check_output("stall_b", DW'(stall_b), DW'(cpu_req && !m_cg()));
            check_output("wen_a", DW'(wen_a), DW'((m_cg() && cpu_we) || (m_hg() && host_we)));
            check_output("wen_b", DW'(wen_b), DW'((m_cg() && cpu_we) || (m_hg() && host_we)));
            check_output("mem_addr_a", DW'(maddr_a), DW'(m_hg() ? host_addr : cpu_addr));
            check_output("mem_data_a", mdata_a, m_hg() ? host_wdata : cpu_wdata);
            check_output("cpu_rv_a",  DW'(cpu_rv_a),  DW'(rv1_v[cyc%NSLOT] && !rv1_t[cyc%NSLOT]));
            check_output("host_rv_a", DW'(host_rv_a), DW'(rv1_v[cyc%NSLOT] &&  rv1_t[cyc%NSLOT]));
            check_output("cpu_rv_b",  DW'(cpu_rv_b),  DW'(rv3_v[cyc%NSLOT] && !rv3_t[cyc%NSLOT]));
            check_output("host_rv_b", DW'(host_rv_b), DW'(rv3_v[cyc%NSLOT] &&  rv3_t[cyc%NSLOT]));
            if (rv1_v[cyc%NSLOT]) check_output("rdata_a", rdata_a, rv1_d[cyc%NSLOT]);
        end
    end

    // Drive one cycle of inputs and capture dut_a outputs mid-cycle.
    task automatic apply_stimulus(input logic cr, input logic cw, input logic [AW-1:0] ca,
                                  input logic [DW-1:0] cd, input logic hr, input logic hw,
                                  input logic [AW-1:0] ha, input logic [DW-1:0] hd, input logic hl);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
        @(negedge clk);
        s_cpu_gnt = cpu_gnt_a; s_host_gnt = host_gnt_a; s_stall = stall_a; s_wen = wen_a;
        s_cpu_rv = cpu_rv_a; s_host_rv = host_rv_a; s_rdata = rdata_a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_lock = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("rst cpu_rv_a",  DW'(cpu_rv_a),  '0);
        check_output("rst host_rv_a", DW'(host_rv_a), '0);
        check_output("rst cpu_rv_b",  DW'(cpu_rv_b),  '0);
        check_output("rst host_rv_b", DW'(host_rv_b), '0);
        check_output("rst wen_a",     DW'(wen_a),     '0);
        check_output("rst gnt_a",     DW'({cpu_gnt_a, host_gnt_a}), '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int wait_run;
    int max_wait;

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = DW'(i) * 64'h0101_0101;
            m_mem[i]   = DW'(i) * 64'h0101_0101;
        end
        env_mem[8'h10] = 64'hDEAD_BEEF;
        m_mem[8'h10]   = 64'hDEAD_BEEF;
        do_reset();

        $display("[TB] CPU alone reads 0x10");
        apply_stimulus(1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check_output("t1 cpu_gnt", DW'(s_cpu_gnt), 1);
        check_output("t1 stall",   DW'(s_stall),   0);
        idle_cycle();
        check_output("t1 cpu_rv",  DW'(s_cpu_rv),  1);
        check_output("t1 host_rv", DW'(s_host_rv), 0);
        check_output("t1 rdata",   s_rdata, 64'hDEAD_BEEF);

        $display("[TB] contended reads alternate from reset");
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(i < 6, 1'b0, AW'(i), '0, i < 6, 1'b0, AW'(i + 8'h40), '0, 1'b0);
            if (i < 6) begin
                check_output("t2 cpu_gnt", DW'(s_cpu_gnt), DW'(i % 2 == 0));
                check_output("t2 stall",   DW'(s_stall),   DW'(i % 2 == 1));
            end
            if (i > 0) begin
                check_output("t2 cpu_rv",  DW'(s_cpu_rv),  DW'((i - 1) % 2 == 0));
                check_output("t2 host_rv", DW'(s_host_rv), DW'((i - 1) % 2 == 1));
            end
        end

        $display("[TB] host lock with continuous contention");
        wait_run = 0;
        max_wait = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, 1'b0, 8'h01, '0, 1'b1, 1'b0, 8'h02, '0, 1'b1);
            check_output("t3 host_gnt", DW'(s_host_gnt), DW'(!(i == 4 || i == 10)));
            wait_run = s_cpu_gnt ? 0 : wait_run + 1;
            if (wait_run > max_wait) max_wait = wait_run;
        end
        check_output("t3 max cpu wait", DW'(max_wait), 5);
        idle_cycle();

        $display("[TB] host write then CPU read of same address");
        apply_stimulus(1'b0, 1'b0, 8'h20, '0, 1'b1, 1'b1, 8'h20, 64'h55, 1'b0);
        check_output("t4 host_gnt", DW'(s_host_gnt), 1);
        check_output("t4 wen",      DW'(s_wen),      1);
        apply_stimulus(1'b1, 1'b0, 8'h20, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check_output("t4 cpu_gnt",  DW'(s_cpu_gnt), 1);
        check_output("t4 wen rd",   DW'(s_wen),     0);
        idle_cycle();
        check_output("t4 cpu_rv",   DW'(s_cpu_rv),  1);
        check_output("t4 rdata",    s_rdata, 64'h55);

        $display("[TB] reset with reads in flight");
        apply_stimulus(1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h11, '0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            check_output("t5 no rv", DW'({cpu_rv_b, host_rv_b, s_cpu_rv, s_host_rv}), 0);
        end

        $display("[TB] idle period keeps arbitration state");
        apply_stimulus(1'b1, 1'b1, 8'h30, 64'h77, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle_cycle();
            check_output("t6 wen", DW'(s_wen), 0);
            check_output("t6 gnt", DW'({s_cpu_gnt, s_host_gnt}), 0);
        end
        apply_stimulus(1'b1, 1'b0, 8'h30, '0, 1'b1, 1'b0, 8'h31, '0, 1'b0);
        check_output("t6 host wins after cpu", DW'(s_host_gnt), 1);
        idle_cycle();
        check_output("t6 host_rv", DW'(s_host_rv), 1);
        idle_cycle();
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
